// File: rtl/imm_gen.sv
// imm_gen: forms the registered 16-bit immediate from Instr[7:0] and the Rd bytes
module imm_gen (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Instr,
  input  logic [1:0]  Imm_Sel,
  input  logic [15:0] Rd,
  output logic [15:0] Imm_Out
);
  logic [7:0]  imm8;
  logic [15:0] imm_out_d, imm_out_q;
  assign imm8 = Instr[7:0];
  always_comb begin
    case (Imm_Sel)
      2'b01:   imm_out_d = {8'h00, imm8};
      2'b10:   imm_out_d = {imm8, Rd[7:0]};
      2'b11:   imm_out_d = {Rd[15:8], imm8};
      default: imm_out_d = {{8{imm8[7]}}, imm8};
    endcase
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) imm_out_q <= '0;
    else       imm_out_q <= imm_out_d;
  assign Imm_Out = imm_out_q;
endmodule

// File: tb/tb_imm_gen.sv
// tb_imm_gen: directed vectors with hand-computed results for imm_gen
module tb_imm_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr, rd, imm_out;
  logic [1:0]  sel;
  int checks = 0, errors = 0;

  imm_gen dut (
    .Clk(clk), .Reset(rst), .Instr(instr), .Imm_Sel(sel), .Rd(rd), .Imm_Out(imm_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [1:0] s, input logic [15:0] i,
                      input logic [15:0] r, input logic [15:0] exp);
    sel = s; instr = i; rd = r;
    @(negedge clk);
    chk(tag, imm_out, exp);
  endtask

  initial begin
    rst = 1'b1; instr = 16'h00EA; rd = 16'hABAB; sel = 2'b00;
    #1 chk("rst_async", imm_out, 16'h0000);
    @(negedge clk); chk("rst_hold0", imm_out, 16'h0000);
    @(negedge clk); chk("rst_hold1", imm_out, 16'h0000);
    rst = 1'b0;
    @(negedge clk); chk("rel_sext", imm_out, 16'hFFEA);
    step("m01", 2'b01, 16'h00EA, 16'hABAB, 16'h00EA);
    step("m10", 2'b10, 16'h00EA, 16'hABAB, 16'hEAAB);
    step("m11", 2'b11, 16'h00EA, 16'hABAB, 16'hABEA);
    #2 rst = 1'b1;
    #1 chk("mid_rst", imm_out, 16'h0000);
    @(negedge clk); chk("mid_hold", imm_out, 16'h0000);
    rst = 1'b0;
    @(negedge clk); chk("mid_rel", imm_out, 16'hABEA);
    step("sext_7f", 2'b00, 16'hFF7F, 16'hABAB, 16'h007F);
    step("sext_80", 2'b00, 16'h0080, 16'hABAB, 16'hFF80);
    step("zext_80", 2'b01, 16'hFF80, 16'hABAB, 16'h0080);
    step("z_m00", 2'b00, 16'h0000, 16'h1234, 16'h0000);
    step("z_m01", 2'b01, 16'hFF00, 16'h1234, 16'h0000);
    step("z_m10", 2'b10, 16'h0000, 16'h1234, 16'h0034);
    step("z_m11", 2'b11, 16'h0000, 16'h1234, 16'h1200);
    step("hi_keep", 2'b10, 16'h0056, 16'h1234, 16'h5634);
    step("lo_keep", 2'b11, 16'h0056, 16'h1234, 16'h1256);
    step("rd_chg", 2'b11, 16'h0056, 16'hCDEF, 16'hCD56);
    sel = 2'b01;
    #1 chk("tog_a", imm_out, 16'hCD56);
    sel = 2'b10;
    #1 chk("tog_b", imm_out, 16'hCD56);
    sel = 2'b01;
    #1 chk("tog_c", imm_out, 16'hCD56);
    @(negedge clk); chk("tog_load", imm_out, 16'h0056);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
